// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM stage and data_mem_ctrl.
// The master drives requests and observes responses; the slave is the memory controller.
interface data_mem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_wdata2;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [31:0]       rsp_rdata2;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_wdata2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rdata2, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_wdata2,
        output req_ready, rsp_valid, rsp_rdata, rsp_rdata2, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressable data memory with valid/ready handshake and 2-beat double accesses.
// Request checking (misalignment / out-of-range rejection) is compiled in with `define DMEM_ERR_EN.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES  = 1024,
    parameter int ADDR_W       = 32,
    parameter int INIT_PATTERN = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DBL  = 1'b1
    } state_t;

    state_t            state_r;
    logic              ready_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;
    logic [31:0]       rsp_rdata2_r;
    logic [31:0]       dbl_word_r;
    logic [IDX_W-1:0]  dbl_idx_r;
    logic              dbl_we_r;
    logic [31:0]       dbl_wdata2_r;
    logic [7:0]        mem_r [DEPTH_BYTES];

    logic              fire_s;
    logic              reject_s;
    logic              is_dbl_s;
    logic [2:0]        align_mask_s;
    logic [ADDR_W-1:0] eff_addr_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [IDX_W-1:0]  port_idx_s;
    logic [IDX_W-1:0]  lane_idx_s [4];
    logic [31:0]       port_word_s;
    logic [31:0]       load_data_s;
    logic              wr_en_s;
    logic [3:0]        wr_lane_s;
    logic [31:0]       wr_data_s;
    logic              unused_addr_s;

`ifdef DMEM_ERR_EN
    logic [3:0]        size_bytes_s;
    logic [ADDR_W:0]   end_addr_s;
`endif

    // Preload image: byte 4k+3 holds the low byte of 4k+4 so word 4k reads 4k+4.
    function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
        if ((INIT_PATTERN != 0) && (idx[1:0] == 2'b11)) begin
            return 8'(32'(idx) + 32'd1);
        end else begin
            return 8'h00;
        end
    endfunction

    // Alignment mask per size code (byte, half, word, double)
    always_comb begin
        case (bus.req_size)
            2'b00:   align_mask_s = 3'b000;
            2'b01:   align_mask_s = 3'b001;
            2'b10:   align_mask_s = 3'b011;
            2'b11:   align_mask_s = 3'b111;
            default: align_mask_s = 3'b000;
        endcase
    end

    // Request acceptance, rejection and effective address
    always_comb begin
        fire_s   = bus.req_valid && ready_r;
        is_dbl_s = (bus.req_size == 2'b11);
`ifdef DMEM_ERR_EN
        size_bytes_s = {1'b0, align_mask_s} + 4'd1;
        end_addr_s   = {1'b0, bus.req_addr} + (ADDR_W + 1)'(size_bytes_s);
        reject_s     = (|(bus.req_addr[2:0] & align_mask_s)) ||
                       (end_addr_s > (ADDR_W + 1)'(DEPTH_BYTES));
        eff_addr_s   = bus.req_addr;
`else
        reject_s     = 1'b0;
        eff_addr_s   = {bus.req_addr[ADDR_W-1:3], bus.req_addr[2:0] & ~align_mask_s};
`endif
    end

    assign req_idx_s     = eff_addr_s[IDX_W-1:0];
    assign unused_addr_s = ^eff_addr_s[ADDR_W-1:IDX_W];

    // Single memory port: beat 1 of a double addresses the latched index + 4, wrapping at the top
    always_comb begin
        if (state_r == ST_DBL) begin
            port_idx_s = dbl_idx_r + IDX_W'(4);
        end else begin
            port_idx_s = req_idx_s;
        end
        for (int k = 0; k < 4; k++) begin
            lane_idx_s[k] = port_idx_s + IDX_W'(k);
        end
        // Storage keeps data XOR the preload image, so cleared storage reads back as the image
        port_word_s = {mem_r[lane_idx_s[0]] ^ init_byte(lane_idx_s[0]),
                       mem_r[lane_idx_s[1]] ^ init_byte(lane_idx_s[1]),
                       mem_r[lane_idx_s[2]] ^ init_byte(lane_idx_s[2]),
                       mem_r[lane_idx_s[3]] ^ init_byte(lane_idx_s[3])};
    end

    // Byte/half loads take the most significant lanes and extend them
    always_comb begin
        case (bus.req_size)
            2'b00: begin
                if (bus.req_sext) begin
                    load_data_s = {{24{port_word_s[31]}}, port_word_s[31:24]};
                end else begin
                    load_data_s = {24'h000000, port_word_s[31:24]};
                end
            end
            2'b01: begin
                if (bus.req_sext) begin
                    load_data_s = {{16{port_word_s[31]}}, port_word_s[31:16]};
                end else begin
                    load_data_s = {16'h0000, port_word_s[31:16]};
                end
            end
            default: load_data_s = port_word_s;
        endcase
    end

    // Write lanes: lane k lands on byte port_idx+k and takes data[31-8k -: 8]
    always_comb begin
        wr_en_s   = 1'b0;
        wr_lane_s = 4'b0000;
        wr_data_s = bus.req_wdata;
        if (state_r == ST_DBL) begin
            wr_en_s   = dbl_we_r;
            wr_lane_s = 4'b1111;
            wr_data_s = dbl_wdata2_r;
        end else begin
            wr_en_s = fire_s && bus.req_we && !reject_s;
            case (bus.req_size)
                2'b00: begin
                    wr_lane_s = 4'b0001;
                    wr_data_s = {bus.req_wdata[7:0], 24'h000000};
                end
                2'b01: begin
                    wr_lane_s = 4'b0011;
                    wr_data_s = {bus.req_wdata[15:0], 16'h0000};
                end
                default: begin
                    wr_lane_s = 4'b1111;
                    wr_data_s = bus.req_wdata;
                end
            endcase
        end
    end

    // Byte-lane storage writes; kept outside reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_lane_s[k]) begin
                    mem_r[lane_idx_s[k]] <= wr_data_s[31-8*k -: 8] ^ init_byte(lane_idx_s[k]);
                end
            end
        end
    end

    // Access FSM and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_err_r    <= 1'b0;
            rsp_rdata_r  <= 32'h00000000;
            rsp_rdata2_r <= 32'h00000000;
            dbl_word_r   <= 32'h00000000;
            dbl_idx_r    <= {IDX_W{1'b0}};
            dbl_we_r     <= 1'b0;
            dbl_wdata2_r <= 32'h00000000;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fire_s) begin
                        if (reject_s) begin
                            rsp_valid_r  <= 1'b1;
                            rsp_err_r    <= 1'b1;
                            rsp_rdata_r  <= 32'h00000000;
                            rsp_rdata2_r <= 32'h00000000;
                        end else if (is_dbl_s) begin
                            state_r      <= ST_DBL;
                            ready_r      <= 1'b0;
                            dbl_idx_r    <= req_idx_s;
                            dbl_we_r     <= bus.req_we;
                            dbl_wdata2_r <= bus.req_wdata2;
                            dbl_word_r   <= port_word_s;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            if (!bus.req_we) begin
                                rsp_rdata_r <= load_data_s;
                            end
                        end
                    end
                end
                ST_DBL: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    if (!dbl_we_r) begin
                        rsp_rdata_r  <= dbl_word_r;
                        rsp_rdata2_r <= port_word_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.rsp_rdata  = rsp_rdata_r;
    assign bus.rsp_rdata2 = rsp_rdata2_r;
endmodule
